// File: rtl/watch_set_ctrl.sv
// Watch time-setting controller: captures live time into shadow registers,
// lets the user edit hour/min/sec with up/down, and strobes the result back.
module watch_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_1hz,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [4:0]  cur_hour,
  input  logic [5:0]  cur_min,
  input  logic [5:0]  cur_sec,
  output logic        set_watch,
  output logic [16:0] bin_watch,
  output logic        edit_active,
  output logic [1:0]  field_sel
);

  typedef enum logic [2:0] {
    IDLE,
    EDIT_HOUR,
    EDIT_MIN,
    EDIT_SEC,
    COMMIT
  } state_t;

  localparam logic [5:0] TIMEOUT_VAL = 6'(TIMEOUT_S);

  state_t     r_state;
  state_t     w_nextState;
  logic [4:0] r_hour;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic [5:0] r_count;
  logic       w_isEdit;
  logic       w_anyBtn;
  logic       w_timeout;
  logic       w_step;

  assign w_isEdit  = (r_state == EDIT_HOUR) || (r_state == EDIT_MIN) || (r_state == EDIT_SEC);
  assign w_anyBtn  = btn_mode || btn_up || btn_down;
  assign w_timeout = w_isEdit && (r_count == TIMEOUT_VAL);
  // An expiring timeout overrides any press in the same cycle; mode beats up/down.
  assign w_step    = w_isEdit && !w_timeout && !btn_mode && (btn_up ^ btn_down);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    set_watch   = 1'b0;
    edit_active = 1'b0;
    field_sel   = 2'd0;
    case (r_state)
      IDLE: begin
        if (btn_mode) w_nextState = EDIT_HOUR;
      end
      EDIT_HOUR: begin
        edit_active = 1'b1;
        field_sel   = 2'd1;
        if (w_timeout)     w_nextState = IDLE;
        else if (btn_mode) w_nextState = EDIT_MIN;
      end
      EDIT_MIN: begin
        edit_active = 1'b1;
        field_sel   = 2'd2;
        if (w_timeout)     w_nextState = IDLE;
        else if (btn_mode) w_nextState = EDIT_SEC;
      end
      EDIT_SEC: begin
        edit_active = 1'b1;
        field_sel   = 2'd3;
        if (w_timeout)     w_nextState = IDLE;
        else if (btn_mode) w_nextState = COMMIT;
      end
      COMMIT: begin
        set_watch   = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hour <= 5'd0;
      r_min  <= 6'd0;
      r_sec  <= 6'd0;
    end else if ((r_state == IDLE) && btn_mode) begin
      r_hour <= cur_hour;
      r_min  <= cur_min;
      r_sec  <= cur_sec;
    end else if (w_step) begin
      case (r_state)
        EDIT_HOUR: begin
          if (btn_up) r_hour <= (r_hour >= 5'd23) ? 5'd0 : r_hour + 5'd1;
          else        r_hour <= ((r_hour == 5'd0) || (r_hour > 5'd23)) ? 5'd23 : r_hour - 5'd1;
        end
        EDIT_MIN: begin
          if (btn_up) r_min <= (r_min >= 6'd59) ? 6'd0 : r_min + 6'd1;
          else        r_min <= ((r_min == 6'd0) || (r_min > 6'd59)) ? 6'd59 : r_min - 6'd1;
        end
        EDIT_SEC: begin
          if (btn_up) r_sec <= (r_sec >= 6'd59) ? 6'd0 : r_sec + 6'd1;
          else        r_sec <= ((r_sec == 6'd0) || (r_sec > 6'd59)) ? 6'd59 : r_sec - 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Outside the edit states the counter sits at zero, so entry to EDIT_HOUR starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_count <= 6'd0;
    else if (!w_isEdit)  r_count <= 6'd0;
    else if (w_anyBtn)   r_count <= 6'd0;
    else if (en_1hz)     r_count <= r_count + 6'd1;
  end

  assign bin_watch = {r_hour, r_min, r_sec};

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: directed scenarios followed by
// random button/tick traffic, all compared against a behavioural model.
module tb_watch_set_ctrl;

  localparam int unsigned TimeoutS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en1hz;
  logic        btnMode;
  logic        btnUp;
  logic        btnDown;
  logic [4:0]  curHour;
  logic [5:0]  curMin;
  logic [5:0]  curSec;
  logic        setWatch;
  logic [16:0] binWatch;
  logic        editActive;
  logic [1:0]  fieldSel;

  int errors = 0;
  int checks = 0;

  // Model: phase 0=idle, 1..3=editing hour/min/sec, 4=commit
  int mPhase;
  int mHour;
  int mMin;
  int mSec;
  int mIdle;

  watch_set_ctrl #(.TIMEOUT_S(TimeoutS)) dut (
    .clk(clk),
    .rst(rst),
    .en_1hz(en1hz),
    .btn_mode(btnMode),
    .btn_up(btnUp),
    .btn_down(btnDown),
    .cur_hour(curHour),
    .cur_min(curMin),
    .cur_sec(curSec),
    .set_watch(setWatch),
    .bin_watch(binWatch),
    .edit_active(editActive),
    .field_sel(fieldSel)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mPhase = 0;
    mHour  = 0;
    mMin   = 0;
    mSec   = 0;
    mIdle  = 0;
  endtask

  task automatic modelStep(input bit mode, input bit up, input bit down, input bit tick);
    int delta;
    delta = (up && !down) ? 1 : ((down && !up) ? -1 : 0);
    if (mPhase == 0) begin
      if (mode) begin
        mPhase = 1;
        mHour  = int'(curHour);
        mMin   = int'(curMin);
        mSec   = int'(curSec);
        mIdle  = 0;
      end
    end else if (mPhase == 4) begin
      mPhase = 0;
    end else if (mIdle == int'(TimeoutS)) begin
      mPhase = 0;
      mIdle  = 0;
    end else begin
      if (mode) mPhase = mPhase + 1;
      else if (mPhase == 1) mHour = (mHour + 24 + delta) % 24;
      else if (mPhase == 2) mMin  = (mMin + 60 + delta) % 60;
      else                  mSec  = (mSec + 60 + delta) % 60;
      if (mode || up || down) mIdle = 0;
      else if (tick)          mIdle = mIdle + 1;
    end
  endtask

  task automatic checkEq(input string tag, input logic [16:0] observed, input logic [16:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [16:0] expBin;
    expBin = {mHour[4:0], mMin[5:0], mSec[5:0]};
    checkEq({tag, ".set_watch"}, 17'(setWatch), 17'(mPhase == 4));
    checkEq({tag, ".edit_active"}, 17'(editActive), 17'((mPhase >= 1) && (mPhase <= 3)));
    checkEq({tag, ".field_sel"}, 17'(fieldSel), ((mPhase >= 1) && (mPhase <= 3)) ? 17'(mPhase) : 17'd0);
    checkEq({tag, ".bin_watch"}, binWatch, expBin);
  endtask

  task automatic applyStimulus(input bit mode, input bit up, input bit down, input bit tick, input string tag);
    btnMode = mode;
    btnUp   = up;
    btnDown = down;
    en1hz   = tick;
    @(posedge clk);
    modelStep(mode, up, down, tick);
    #1;
    btnMode = 1'b0;
    btnUp   = 1'b0;
    btnDown = 1'b0;
    en1hz   = 1'b0;
    checkOutput(tag);
  endtask

  task automatic pulseReset(input string tag);
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".async"});
    @(posedge clk);
    #1;
    checkOutput({tag, ".held"});
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    en1hz   = 1'b0;
    btnMode = 1'b0;
    btnUp   = 1'b0;
    btnDown = 1'b0;
    curHour = 5'd0;
    curMin  = 6'd0;
    curSec  = 6'd0;
    modelReset();
    #2;
    checkOutput("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Up/down while idle do nothing
    curHour = 5'd5; curMin = 6'd6; curSec = 6'd7;
    applyStimulus(0, 1, 0, 0, "idleUp");
    applyStimulus(0, 0, 1, 1, "idleDown");
    applyStimulus(0, 1, 1, 0, "idleBoth");

    // Full edit-and-commit walk
    curHour = 5'd10; curMin = 6'd20; curSec = 6'd30;
    applyStimulus(1, 0, 0, 0, "walkEnter");
    applyStimulus(0, 1, 0, 0, "walkHourUp");
    applyStimulus(1, 0, 0, 0, "walkToMin");
    applyStimulus(0, 0, 1, 0, "walkMinDown1");
    applyStimulus(0, 0, 1, 0, "walkMinDown2");
    applyStimulus(1, 0, 0, 0, "walkToSec");
    applyStimulus(1, 0, 0, 0, "walkCommit");
    checkEq("walkCommitStrobe", 17'(setWatch), 17'd1);
    checkEq("walkCommitValue", binWatch, {5'd11, 6'd18, 6'd30});
    applyStimulus(1, 1, 0, 0, "walkBackIdle");

    // Wrap upward at the top of the range
    curHour = 5'd23; curMin = 6'd59; curSec = 6'd0;
    applyStimulus(1, 0, 0, 0, "wrapUpEnter");
    applyStimulus(0, 1, 0, 0, "wrapUpHour");
    applyStimulus(1, 0, 0, 0, "wrapUpToMin");
    applyStimulus(0, 1, 0, 0, "wrapUpMin");
    checkEq("wrapUpValue", binWatch, {5'd0, 6'd0, 6'd0});
    applyStimulus(1, 0, 0, 0, "wrapUpToSec");
    applyStimulus(1, 0, 0, 0, "wrapUpCommit");
    applyStimulus(0, 0, 0, 0, "wrapUpIdle");

    // Wrap downward at zero
    curHour = 5'd0; curMin = 6'd0; curSec = 6'd0;
    applyStimulus(1, 0, 0, 0, "wrapDnEnter");
    applyStimulus(0, 0, 1, 0, "wrapDnHour");
    applyStimulus(1, 0, 0, 0, "wrapDnToMin");
    applyStimulus(0, 0, 1, 0, "wrapDnMin");
    applyStimulus(1, 0, 0, 0, "wrapDnToSec");
    applyStimulus(0, 0, 1, 0, "wrapDnSec");
    checkEq("wrapDnValue", binWatch, {5'd23, 6'd59, 6'd59});
    applyStimulus(1, 0, 0, 0, "wrapDnCommit");
    applyStimulus(0, 0, 0, 0, "wrapDnIdle");

    // Simultaneous buttons
    curHour = 5'd8; curMin = 6'd40; curSec = 6'd15;
    applyStimulus(1, 0, 0, 0, "bothEnter");
    applyStimulus(1, 0, 0, 0, "bothToMin");
    applyStimulus(0, 1, 1, 0, "bothUpDown");
    applyStimulus(1, 0, 0, 0, "bothToSec");
    applyStimulus(1, 0, 0, 0, "bothCommit");
    applyStimulus(0, 0, 0, 0, "bothIdle");
    applyStimulus(1, 0, 0, 0, "modeUpEnter");
    applyStimulus(1, 1, 0, 0, "modeUpHour");
    checkEq("modeUpField", 17'(fieldSel), 17'd2);
    checkEq("modeUpValue", binWatch, {5'd8, 6'd40, 6'd15});

    // Timeout after three idle ticks, no commit strobe
    applyStimulus(0, 0, 0, 1, "toTick1");
    applyStimulus(0, 0, 0, 1, "toTick2");
    applyStimulus(0, 0, 0, 1, "toTick3");
    applyStimulus(0, 0, 0, 0, "toExpire");
    checkEq("toExpireEdit", 17'(editActive), 17'd0);

    // A press before the third tick restarts the count
    applyStimulus(1, 0, 0, 0, "toRestartEnter");
    applyStimulus(0, 0, 0, 1, "toRestartTick1");
    applyStimulus(0, 0, 0, 1, "toRestartTick2");
    applyStimulus(0, 1, 1, 1, "toRestartPress");
    applyStimulus(0, 0, 0, 1, "toRestartTick3");
    applyStimulus(0, 0, 0, 1, "toRestartTick4");
    checkEq("toRestartStillEdit", 17'(editActive), 17'd1);
    applyStimulus(0, 0, 0, 1, "toRestartTick5");
    applyStimulus(0, 0, 0, 0, "toRestartExpire");

    // Reset in the middle of an edit
    curHour = 5'd14; curMin = 6'd33; curSec = 6'd44;
    applyStimulus(1, 0, 0, 0, "rstEnter");
    applyStimulus(1, 0, 0, 0, "rstToMin");
    applyStimulus(1, 0, 0, 0, "rstToSec");
    applyStimulus(0, 1, 0, 0, "rstSecUp");
    pulseReset("rstMidEdit");
    curHour = 5'd1; curMin = 6'd2; curSec = 6'd3;
    applyStimulus(0, 0, 0, 1, "rstAfterIdle");
    applyStimulus(1, 0, 0, 0, "rstRecapture");
    checkEq("rstRecaptureValue", binWatch, {5'd1, 6'd2, 6'd3});
    applyStimulus(1, 0, 0, 0, "rstToMin2");
    applyStimulus(1, 0, 0, 0, "rstToSec2");
    applyStimulus(1, 0, 0, 0, "rstCommit");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      curHour = 5'($urandom_range(23));
      curMin  = 6'($urandom_range(59));
      curSec  = 6'($urandom_range(59));
      if ($urandom_range(149) == 0) pulseReset("randReset");
      applyStimulus(($urandom_range(7) == 0), ($urandom_range(4) == 0),
                    ($urandom_range(4) == 0), ($urandom_range(1) == 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/watch_set_ctrl.md
WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

Parameters
REQ-001 TIMEOUT_S, default 30: number of idle en_1hz ticks in an edit state before the edit is abandoned (legal range 1..63).

Interface
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 en_1hz  input  1  one-clk-wide pulse, once per second.
REQ-005 btn_mode  input  1  debounced one-clk pulse: enter edit or advance to the next field.
REQ-006 btn_up  input  1  debounced one-clk pulse: increment the selected field.
REQ-007 btn_down  input  1  debounced one-clk pulse: decrement the selected field.
REQ-008 cur_hour / cur_min / cur_sec  input  5/6/6  live time from the timekeeper.
REQ-009 set_watch  output  1  one-clk load strobe to the timekeeper.
REQ-010 bin_watch  output  17  {hour[4:0], min[5:0], sec[5:0]}, driven from the shadow registers.
REQ-011 edit_active  output  1  high while in any EDIT state.
REQ-012 field_sel  output  2  selected field: 0=none, 1=hour, 2=min, 3=sec.

Function
REQ-013 FSM states SHALL be IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC and COMMIT, all registered.
REQ-014 IDLE + btn_mode -> EDIT_HOUR; same edge, the shadow registers SHALL capture cur_hour, cur_min and cur_sec.
REQ-015 Mode advances EDIT_HOUR -> EDIT_MIN -> EDIT_SEC -> COMMIT.
REQ-016 COMMIT SHALL last exactly one clk, with set_watch=1 and bin_watch holding the shadow value, then return to IDLE unconditionally.
REQ-017 set_watch SHALL be 0 in every state other than COMMIT.
REQ-018 Up/down SHALL act only on the selected field:
- hour wraps 23 -> 0 on up and 0 -> 23 on down;
- min and sec wrap 59 -> 0 on up and 0 -> 59 on down.
REQ-019 btn_up and btn_down asserted in the same cycle SHALL leave the field unchanged, but SHALL still reset the timeout counter.
REQ-020 btn_mode asserted with btn_up or btn_down SHALL take priority; the up/down press is discarded that cycle.
REQ-021 Up/down in IDLE or COMMIT SHALL be ignored.
- btn_mode in COMMIT is ignored.
- The shadow registers hold their value outside the EDIT states.
REQ-022 Timeout counter (6 bits):
- cleared on entry to EDIT_HOUR and on any button press;
- incremented on en_1hz while in an EDIT state;
- a press and en_1hz in the same cycle -> counter = 0.
REQ-023 When the counter reaches TIMEOUT_S, the FSM SHALL go to IDLE on the next clk without asserting set_watch; bin_watch keeps its last shadow value.
REQ-024 edit_active = 1 in EDIT_*; field_sel = 0 in IDLE and COMMIT.
REQ-025 The shadow fields SHALL never hold out-of-range values (hour <= 23, min/sec <= 59), provided the captured inputs are in range.

Reset
REQ-026 On rst=0, asynchronously:
- state = IDLE;
- shadow registers, timeout counter, set_watch, edit_active and field_sel = 0;
- bin_watch = 17'd0.
REQ-027 Reset asserted mid-edit SHALL abandon the edit, with no set_watch pulse during or after reset.
REQ-028 After reset release, the first btn_mode SHALL recapture live time.

Verification
REQ-029 cur = 10:20:30; mode, up, mode, down x2, mode, mode -> exactly one clk with set_watch=1 and bin_watch = {11, 18, 30}; back in IDLE.
REQ-030 cur = 23:59:00, hour up then min up -> shadow hour 0, min 0; cur = 00:00:00, down on each field -> 23:59:59.
REQ-031 EDIT_MIN with btn_up and btn_down together -> min unchanged; mode+up together in EDIT_HOUR -> moves to EDIT_MIN, hour unchanged.
REQ-032 TIMEOUT_S = 3: enter edit, then 3 en_1hz pulses with no buttons -> IDLE, set_watch never high; a press before the third pulse restarts the count.
REQ-033 rst pulsed low in EDIT_SEC -> outputs 0 immediately; the next mode recaptures cur_* and set_watch stays 0 until a COMMIT.
REQ-034 up/down pulses in IDLE -> no state change, field_sel = 0, set_watch = 0.
